fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch stage directly upstream of the datapath decode glue.
- Owns the PC register and fetches from instruction memory over a req/ack handshake.
- Holds the fetched Order word stable for the datapath and selects the next PC: sequential, branch, jump or jr.
- Honours the PC-enable (halt/Go) signal and emits a one-cycle commit pulse that downstream writes gate on.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  PC-advance permission from the PC-enable logic; low = stall (syscall halt until Go).
- Branch  in  1  conditional branch taken, evaluated in EXEC.
- Jump  in  1  j/jal, absolute target.
- Jr  in  1  jump register.
- ext18  in  32  sign-extended, shifted branch offset.
- R1_out  in  32  register value used for the jr target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address, equals PC.
- imem_ack  in  1  memory data valid, may arrive 1..N cycles after req.
- imem_data  in  32  instruction word, sampled on ack.
- Order  out  32  current instruction, held stable outside FETCH.
- Order_valid  out  1  Order is valid (state EXEC).
- commit  out  1  single-cycle pulse: instruction retires this cycle.
- PC  out  32  address of Order.
- PC_plus_4  out  32  PC + 4, wraps modulo 2^32.
- misalign  out  1  sticky flag: a jr target had bits [1:0] nonzero.
- cycle_cnt  out  CNT_W  cycles since reset.
- instr_cnt  out  CNT_W  committed instructions.
- branch_cnt  out  CNT_W  committed taken Branch/Jump/Jr instructions.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, Order=0, state=FETCH.
  - Order_valid=0, commit=0, imem_req=0, misalign=0, all counters=0.
  - imem_req rises on the first clk edge after rst_n deasserts.
- State FETCH:
  - imem_req=1, imem_addr=PC, Order_valid=0, commit=0.
  - On a cycle with imem_ack=1: Order<=imem_data, imem_req<=0, go EXEC.
  - imem_ack outside FETCH is ignored.
- State EXEC:
  - Order_valid=1; combinational decode downstream operates on Order.
  - enable=0: remain in EXEC, PC and Order unchanged, commit=0, no counter change other than cycle_cnt.
  - enable=1: commit=1 this cycle, PC<=next_pc, go FETCH.
  - Fetch latency is therefore ack delay + 1 EXEC cycle; best case 2 cycles per instruction.
- next_pc priority is Jr > Jump > Branch > sequential:
  - Jr: {R1_out[31:2],2'b00}; sets misalign if R1_out[1:0]!=0.
  - Jump: {PC_plus_4[31:28],Order[25:0],2'b00}.
  - Branch: PC_plus_4+ext18, 32-bit wrap.
  - Otherwise: PC_plus_4.
  - Simultaneous flags resolve by this priority.
- Control inputs (Branch, Jump, Jr, enable) are sampled only in EXEC.
- misalign clears only on reset.
- Counters saturate at all-ones and never wrap:
  - cycle_cnt increments every cycle after reset.
  - instr_cnt increments on commit.
  - branch_cnt increments on commit when Jr|Jump|Branch.
- Reset mid-FETCH abandons the request immediately; a late ack after reset, while req is not yet re-asserted, is ignored.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: cycle_cnt, instr_cnt and branch_cnt are implemented as above.
- Undefined: no counter registers are built; all three ports are tied to 0.
- Handshake, PC and commit behaviour are identical in both builds.

Test Plan:
- Reset, RESET_PC=0, ack one cycle after req with data 32'h20080005, enable=1 -> Order=32'h20080005 in EXEC, one commit, PC=4, next imem_addr=4.
- EXEC with enable=0 held 5 cycles, then 1 -> no commit, PC and Order constant for 5 cycles; exactly one commit after release; instr_cnt+1, cycle_cnt+6.
- PC=32'h100, Branch=1, ext18=32'hFFFFFFF8 -> next PC=32'h000000FC; branch_cnt+1.
- PC=32'h0040_0000, Order=32'h0810_0010, Jump=1 and Branch=1 together -> next PC=32'h0040_0040 (Jump wins).
- Jr=1, R1_out=32'h0000_0206 -> next PC=32'h0000_0204, misalign=1 and stays 1 after further commits.
- rst_n pulsed low while imem_req=1 waiting for ack -> imem_req=0 and PC=RESET_PC immediately; a subsequent stray ack is ignored; a new fetch starts cleanly.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, holds Order for decode
// and selects the next PC. Statistics counters are built only when FETCH_STATS_EN is defined.
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             Jr,
  input  logic [31:0]      ext18,
  input  logic [31:0]      R1_out,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic [31:0]      Order,
  output logic             Order_valid,
  output logic             commit,
  output logic [31:0]      PC,
  output logic [31:0]      PC_plus_4,
  output logic             misalign,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] order_q, order_d;
  logic        req_q, req_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus_4;
  logic [31:0] next_pc;
  logic        retire;
  logic        accept;

  assign pc_plus_4 = pc_q + 32'd4;
  assign retire    = (state_q == S_EXEC) && enable;
  // An ack only counts while a request is actually outstanding, so a stray ack
  // right after reset (req still low) is dropped.
  assign accept    = (state_q == S_FETCH) && req_q && imem_ack;

  always_comb begin
    next_pc = pc_plus_4;
    if (Jr)
      next_pc = {R1_out[31:2], 2'b00};
    else if (Jump)
      next_pc = {pc_plus_4[31:28], order_q[25:0], 2'b00};
    else if (Branch)
      next_pc = pc_plus_4 + ext18;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    order_d    = order_q;
    req_d      = req_q;
    misalign_d = misalign_q;
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          order_d = imem_data;
          req_d   = 1'b0;
          state_d = S_EXEC;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_EXEC: begin
        if (retire) begin
          pc_d    = next_pc;
          req_d   = 1'b1;
          state_d = S_FETCH;
          if (Jr && (R1_out[1:0] != 2'b00))
            misalign_d = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      order_q    <= 32'h0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      order_q    <= order_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign Order       = order_q;
  assign Order_valid = (state_q == S_EXEC);
  assign commit      = retire;
  assign PC          = pc_q;
  assign PC_plus_4   = pc_plus_4;
  assign misalign    = misalign_q;

`ifdef FETCH_STATS_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    cycle_cnt_d  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    instr_cnt_d  = instr_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (retire && !(&instr_cnt_q))
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    if (retire && (Jr || Jump || Branch) && !(&branch_cnt_q))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign branch_cnt = branch_cnt_q;
`else
  assign cycle_cnt  = '0;
  assign instr_cnt  = '0;
  assign branch_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table of instructions plus reset corner cases.
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable, Branch, Jump, Jr;
  logic [31:0]      ext18, R1_out;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_data;
  logic [31:0]      Order;
  logic             Order_valid, commit;
  logic [31:0]      PC, PC_plus_4;
  logic             misalign;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt, branch_cnt;

  fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .Branch(Branch), .Jump(Jump), .Jr(Jr),
    .ext18(ext18), .R1_out(R1_out), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .Order(Order), .Order_valid(Order_valid),
    .commit(commit), .PC(PC), .PC_plus_4(PC_plus_4), .misalign(misalign),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .branch_cnt(branch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          delay;
    int          stall;
    logic        br;
    logic        jp;
    logic        jr;
    logic [31:0] ext;
    logic [31:0] r1;
    logic [31:0] next_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] order;
  } exp_t;

  vec_t        vec [13];
  exp_t        exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          tb_cyc = 0;
  int          exp_instr = 0;
  int          exp_br = 0;
  logic        exp_mis = 1'b0;
  logic [31:0] cur_pc = RESET_PC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference cycle count: one per rising edge while out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc = 0;
    else        tb_cyc = tb_cyc + 1;
  end

  // Scoreboard: every observed commit must match the oldest fetched instruction.
  always @(posedge clk) begin
    if (rst_n && commit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_pc", PC, e.pc);
        chk("commit_order", Order, e.order);
      end
    end
  end

  task automatic chk_counters(input string tag);
`ifdef FETCH_STATS_EN
    chk({tag, "_cycle_cnt"}, cycle_cnt, tb_cyc);
    chk({tag, "_instr_cnt"}, instr_cnt, exp_instr);
    chk({tag, "_branch_cnt"}, branch_cnt, exp_br);
`else
    chk({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
    chk({tag, "_instr_cnt"}, instr_cnt, 32'd0);
    chk({tag, "_branch_cnt"}, branch_cnt, 32'd0);
`endif
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_req();
    chk("fetch_addr", imem_addr, cur_pc);
    chk("fetch_order_valid", {31'd0, Order_valid}, 32'd0);
    exp_q.push_back('{pc: cur_pc, order: v.data});
    repeat (v.delay) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = v.data;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = $urandom;
    chk("exec_valid", {31'd0, Order_valid}, 32'd1);
    chk("exec_order", Order, v.data);
    chk("exec_req_low", {31'd0, imem_req}, 32'd0);
    Branch = v.br;
    Jump   = v.jp;
    Jr     = v.jr;
    ext18  = v.ext;
    R1_out = v.r1;
    for (int s = 0; s < v.stall; s++) begin
      enable    = 1'b0;
      imem_ack  = 1'b1;
      imem_data = 32'hBAD0_BAD0;
      #1 chk("stall_no_commit", {31'd0, commit}, 32'd0);
      @(negedge clk);
      chk("stall_order", Order, v.data);
      chk("stall_pc", PC, cur_pc);
    end
    imem_ack = 1'b0;
    enable   = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    Branch = 1'b0;
    Jump   = 1'b0;
    Jr     = 1'b0;
    chk("committed", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_instr++;
    if (v.br || v.jp || v.jr) exp_br++;
    if (v.jr && (v.r1[1:0] != 2'b00)) exp_mis = 1'b1;
    cur_pc = v.next_pc;
    chk("next_pc", PC, cur_pc);
    chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    chk_counters("post_commit");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004};
    vec[1]  = '{32'h0109_5020, 0, 5, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008};
    vec[2]  = '{32'h03E0_0008, 2, 0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0100, 32'h0000_0100};
    vec[3]  = '{32'h1109_FFFE, 0, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_00FC};
    vec[4]  = '{32'h0320_0008, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0040_0000, 32'h0040_0000};
    vec[5]  = '{32'h0810_0010, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0040_0040};
    vec[6]  = '{32'h0C00_0000, 1, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0206, 32'h0000_0204};
    vec[7]  = '{32'hAC00_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0208};
    vec[8]  = '{32'h1000_0004, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_021C};
    vec[9]  = '{32'h0340_0008, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vec[10] = '{32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000};
    vec[11] = '{32'h1234_0000, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF4};
    vec[12] = '{32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC};

    rst_n = 1'b0;
    enable = 1'b0; Branch = 1'b0; Jump = 1'b0; Jr = 1'b0;
    ext18 = 32'h0; R1_out = 32'h0; imem_ack = 1'b0; imem_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", PC, RESET_PC);
    chk("rst_order", Order, 32'h0);
    chk("rst_valid", {31'd0, Order_valid}, 32'd0);
    chk("rst_commit", {31'd0, commit}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk_counters("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vec[i]);

    // Reset while a fetch is outstanding, then a stray ack before req re-asserts.
    wait_req();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", PC, RESET_PC);
    chk("midrst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack  = 1'b0;
    chk("stray_ack_req", {31'd0, imem_req}, 32'd1);
    chk("stray_ack_valid", {31'd0, Order_valid}, 32'd0);
    chk("stray_ack_order", Order, 32'h0);
    exp_q.delete();
    exp_instr = 0;
    exp_br    = 0;
    exp_mis   = 1'b0;
    cur_pc    = RESET_PC;
    run_vec(vec[0]);
    run_vec(vec[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
